// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 scancode controller
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXTEND = 8'hE0;

  // "release" is a reserved word, hence is_release.
  typedef struct packed {
    logic [7:0] code;
    logic       is_release;
  } ps2_event_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// rtl/ps2_event_fifo.sv - synchronous key-event FIFO, DEPTH x 9 bits
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  ps2_event_t push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output ps2_event_t head
);

  localparam int AW = $clog2(DEPTH);

  ps2_event_t    mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A simultaneous pop frees the slot being written when full.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Storage array, written at the tail.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Read/write pointers with wrap bit for full/empty distinction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_scancode_controller.sv
// rtl/ps2_scancode_controller.sv - PS/2 frame receiver, break decode and event queue (optional PS2_PARITY_CHECK_EN)
module ps2_scancode_controller
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       kb_clock,
  input  logic       kb_data,
  input  logic       ev_ready,
  output logic       ev_valid,
  output logic [7:0] ev_code,
  output logic       ev_release,
  output logic       frame_error,
  output logic       overflow,
  output logic       busy
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          clk_diff;
  logic          filt_done;
  logic          kb_fall;
  logic          kb_bit;

  rx_state_t     state;
  rx_state_t     state_next;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [TW-1:0] tcnt;
  logic          timeout;
  logic          parity_ok;
  logic          stop_ok;
  logic          stop_bad;
  logic          rx_valid;

  logic          break_pending;
  logic          push;
  ps2_event_t    push_ev;
  ps2_event_t    head;
  logic          full;
  logic          empty;
  logic          pop;

  // Two-flop synchronizers, preset to the idle-high bus level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], kb_clock};
      dat_sync <= {dat_sync[0], kb_data};
    end
  end

  assign clk_diff  = (clk_sync[1] != clk_filt);
  assign filt_done = clk_diff && (filt_cnt == FW'(FILTER_LEN - 1));
  assign kb_fall   = filt_done && clk_filt;
  assign kb_bit    = dat_sync[1];

  // Glitch filter: kb_clock must hold a new level FILTER_LEN cycles before it is accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (!clk_diff) begin
      filt_cnt <= '0;
    end else if (filt_done) begin
      clk_filt <= clk_sync[1];
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit;
  assign parity_ok = ^{shreg, par_bit};

  // Capture the parity bit for the odd-parity check at STOP.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) par_bit <= 1'b0;
    else if (kb_fall && state == PARITY) par_bit <= kb_bit;
  end
`else
  assign parity_ok = 1'b1;
`endif

  assign timeout = (state != IDLE) && !kb_fall && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  // Receive FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic and end-of-frame verdict.
  always_comb begin
    state_next = state;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;
    if (timeout) begin
      state_next = IDLE;
    end else if (kb_fall) begin
      case (state)
        IDLE:    if (!kb_bit) state_next = DATA;
        DATA:    if (bit_cnt == 3'd7) state_next = PARITY;
        PARITY:  state_next = STOP;
        STOP: begin
          state_next = IDLE;
          if (kb_bit && parity_ok) stop_ok  = 1'b1;
          else                     stop_bad = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Shift register, bit counter, inter-edge timeout and frame result pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt     <= '0;
      shreg       <= '0;
      tcnt        <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      rx_valid    <= stop_ok;
      frame_error <= stop_bad | timeout;
      if (state == IDLE || kb_fall) tcnt <= '0;
      else                          tcnt <= tcnt + 1'b1;
      if (state == IDLE) bit_cnt <= '0;
      if (kb_fall && state == DATA) begin
        shreg   <= {kb_bit, shreg[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // Byte decode: F0 arms a release, E0 is dropped, anything else becomes an event.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      break_pending <= 1'b0;
      push          <= 1'b0;
      push_ev       <= '0;
    end else begin
      push <= 1'b0;
      if (rx_valid) begin
        if (shreg == PS2_BREAK) begin
          break_pending <= 1'b1;
        end else if (shreg != PS2_EXTEND) begin
          push          <= 1'b1;
          push_ev       <= '{code: shreg, is_release: break_pending};
          break_pending <= 1'b0;
        end
      end
    end
  end

  // Sticky overflow when an event arrives at a full FIFO with no pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                     overflow <= 1'b0;
    else if (push && full && !pop) overflow <= 1'b1;
  end

  ps2_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_ev),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  assign ev_valid   = ~empty;
  assign pop        = ev_valid & ev_ready;
  assign ev_code    = head.code;
  assign ev_release = head.is_release;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_ps2_scancode_controller.sv
// tb/tb_ps2_scancode_controller.sv - self-checking bench for ps2_scancode_controller
module tb_ps2_scancode_controller;

  localparam int HALF    = 25;
  localparam int TIMEOUT = 1000;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       kb_clock = 1'b1;
  logic       kb_data = 1'b1;
  logic       ev_ready = 1'b1;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_release;
  logic       frame_error;
  logic       overflow;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  int ferr_cnt = 0;
  logic [8:0] exp_q [$];

  typedef struct {
    logic [7:0] b;
    logic       flip;
    logic       ev;
    logic [7:0] code;
    logic       rel;
    int         ferr;
  } vec_t;

  vec_t vecs [12];

  ps2_scancode_controller #(
    .FILTER_LEN     (8),
    .TIMEOUT_CYCLES (TIMEOUT),
    .FIFO_DEPTH     (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .kb_clock    (kb_clock),
    .kb_data     (kb_data),
    .ev_ready    (ev_ready),
    .ev_valid    (ev_valid),
    .ev_code     (ev_code),
    .ev_release  (ev_release),
    .frame_error (frame_error),
    .overflow    (overflow),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Scoreboard: compare every accepted event against the head of the expected queue.
  always @(negedge clock) begin
    if (!reset && ev_valid && ev_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: got code %0h rel %0b expected none", ev_code, ev_release);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("ev_code", 32'(ev_code), 32'(e[8:1]));
        check("ev_release", 32'(ev_release), 32'(e[0]));
      end
    end
    if (!reset && frame_error) ferr_cnt++;
  end

  task automatic kb_bit_out(input logic b);
    kb_data = b;
    tick(HALF);
    kb_clock = 1'b0;
    tick(HALF);
    kb_clock = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip_par);
    logic p;
    p = (~^b) ^ flip_par;
    kb_bit_out(1'b0);
    for (int i = 0; i < 8; i++) kb_bit_out(b[i]);
    kb_bit_out(p);
    kb_bit_out(1'b1);
    kb_data = 1'b1;
    tick(HALF);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int f0;
    vecs[0]  = '{8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0, 0};
    vecs[1]  = '{8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 0};
    vecs[2]  = '{8'h1C, 1'b0, 1'b1, 8'h1C, 1'b1, 0};
    vecs[3]  = '{8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 0};
    vecs[4]  = '{8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 0};
    vecs[5]  = '{8'h75, 1'b0, 1'b1, 8'h75, 1'b1, 0};
    vecs[6]  = '{8'h12, 1'b0, 1'b1, 8'h12, 1'b0, 0};
    vecs[7]  = '{8'h12, 1'b0, 1'b1, 8'h12, 1'b0, 0};
    vecs[8]  = '{8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 0};
    vecs[9]  = '{8'h75, 1'b0, 1'b1, 8'h75, 1'b0, 0};
`ifdef PS2_PARITY_CHECK_EN
    vecs[10] = '{8'h1C, 1'b1, 1'b0, 8'h00, 1'b0, 1};
`else
    vecs[10] = '{8'h1C, 1'b1, 1'b1, 8'h1C, 1'b0, 0};
`endif
    vecs[11] = '{8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 0};

    tick(5);
    check("rst_ev_valid", 32'(ev_valid), 32'd0);
    check("rst_frame_error", 32'(frame_error), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick(20);

    for (int i = 0; i < 12; i++) begin
      f0 = ferr_cnt;
      if (vecs[i].ev) exp_q.push_back({vecs[i].code, vecs[i].rel});
      send_frame(vecs[i].b, vecs[i].flip);
      wait_drain($sformatf("vec%0d_drain", i));
      check($sformatf("vec%0d_ferr", i), 32'(ferr_cnt - f0), 32'(vecs[i].ferr));
    end
    tick(5);
    check("idle_ev_valid", 32'(ev_valid), 32'd0);

    // Timeout: start bit plus four data bits, then the clock stops.
    f0 = ferr_cnt;
    kb_bit_out(1'b0);
    for (int i = 0; i < 4; i++) kb_bit_out(1'b1);
    kb_data = 1'b1;
    check("to_busy_mid", 32'(busy), 32'd1);
    for (int i = 0; i < TIMEOUT + 200 && ferr_cnt == f0; i++) tick(1);
    check("to_ferr", 32'(ferr_cnt - f0), 32'd1);
    tick(2);
    check("to_busy_after", 32'(busy), 32'd0);
    exp_q.push_back({8'h1C, 1'b0});
    send_frame(8'h1C, 1'b0);
    wait_drain("to_recover_drain");

    // Reset in the middle of a frame: nothing emitted.
    f0 = ferr_cnt;
    kb_bit_out(1'b0);
    for (int i = 0; i < 3; i++) kb_bit_out(1'b0);
    check("rmf_busy_mid", 32'(busy), 32'd1);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    kb_data = 1'b1;
    tick(100);
    check("rmf_busy", 32'(busy), 32'd0);
    check("rmf_ev_valid", 32'(ev_valid), 32'd0);
    check("rmf_ferr", 32'(ferr_cnt - f0), 32'd0);

    // Overflow: five make codes into a four-entry FIFO with the consumer stalled.
    ev_ready = 1'b0;
    send_frame(8'h15, 1'b0);
    send_frame(8'h16, 1'b0);
    send_frame(8'h1A, 1'b0);
    check("ovf_before_full", 32'(overflow), 32'd0);
    send_frame(8'h1B, 1'b0);
    check("ovf_at_full", 32'(overflow), 32'd0);
    send_frame(8'h1C, 1'b0);
    tick(10);
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("ovf_hold_valid", 32'(ev_valid), 32'd1);
    check("ovf_hold_code", 32'(ev_code), 32'h15);
    tick(30);
    check("ovf_hold_code2", 32'(ev_code), 32'h15);
    check("ovf_hold_rel", 32'(ev_release), 32'd0);
    exp_q.push_back({8'h15, 1'b0});
    exp_q.push_back({8'h16, 1'b0});
    exp_q.push_back({8'h1A, 1'b0});
    exp_q.push_back({8'h1B, 1'b0});
    ev_ready = 1'b1;
    wait_drain("ovf_drain");
    tick(10);
    check("ovf_empty", 32'(ev_valid), 32'd0);
    check("ovf_still_set", 32'(overflow), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
